// File: rtl/angle_sequence_recorder.sv
// -----------------------------------------------------------------------------
// angle_sequence_recorder
//
// Writer side of the angle-sequence memory. On a start request it samples the
// three selected servo angles (sign + 16-bit magnitude) once every TICKS clock
// cycles into an on-chip RAM, until a stop request arrives or the RAM is full.
// The stored sequence is what the playback generator later replays. A
// free-running synchronous read port exposes the stored samples.
//
// Ports
//   clk                 system clock
//   rst_a               asynchronous reset, active-high
//   rec_start           start request (level, acted on at its rising edge)
//   rec_stop            stop request  (level, acted on at its rising edge)
//   servoN_angle        servo N magnitude, N = 1..3
//   servoN_is_negative  servo N sign,      N = 1..3
//   rd_addr             read address
//   rd_data             mem[rd_addr] one cycle later,
//                       {s1_neg,s1_abs,s2_neg,s2_abs,s3_neg,s3_abs}
//   rec_count           number of valid words written (0..MEMORY_SIZE)
//   recording           high while a recording is in progress
//   done                high once a recording has ended
//   overflow            high if the last recording ended because memory filled
// -----------------------------------------------------------------------------
module angle_sequence_recorder #(
    parameter int unsigned TIME_MS       = 125,
    parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
    parameter int unsigned MEMORY_SIZE   = 128,
    parameter int unsigned ADDR_W        = 7
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic [15:0]       servo1_angle,
    input  logic              servo1_is_negative,
    input  logic [15:0]       servo2_angle,
    input  logic              servo2_is_negative,
    input  logic [15:0]       servo3_angle,
    input  logic              servo3_is_negative,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [50:0]       rd_data,
    output logic [ADDR_W:0]   rec_count,
    output logic              recording,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned TICKS  = CLOCK_FREQ_HZ / 1000 * TIME_MS;
    localparam int unsigned TICK_W = $clog2(TICKS);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 51;

    // WAIT ends at TICKS-2 so that CAPTURE + WAIT cycles add up to TICKS,
    // giving exactly TICKS cycles between consecutive RAM writes.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 2);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(MEMORY_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TICK_W-1:0]  tick_q;
    logic [TICK_W-1:0]  tick_d;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   count_inc;
    logic               overflow_d;
    logic               start_q;
    logic               stop_q;
    logic               start_edge;
    logic               stop_edge;
    logic               mem_we;
    logic [WORD_W-1:0]  wr_word;

    logic [WORD_W-1:0]  mem [MEMORY_SIZE];

    // Requests are already synchronous to clk; only rising edges are events.
    assign start_edge = rec_start & ~start_q;
    assign stop_edge  = rec_stop  & ~stop_q;

    assign count_inc = rec_count + CNT_W'(1);

    assign wr_word = {servo1_is_negative, servo1_angle,
                      servo2_is_negative, servo2_angle,
                      servo3_is_negative, servo3_angle};

    // -------------------------------------------------------------------------
    // State and control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            rec_count <= '0;
            overflow  <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            rec_count <= count_d;
            overflow  <= overflow_d;
            start_q   <= rec_start;
            stop_q    <= rec_stop;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, datapath updates and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        count_d    = rec_count;
        overflow_d = overflow;
        mem_we     = 1'b0;
        recording  = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                // A simultaneous stop edge cancels the start.
                if (start_edge && !stop_edge) begin
                    state_d    = S_CAPTURE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end

            S_CAPTURE: begin
                recording = 1'b1;
                // The write always completes, even if a stop edge arrives now.
                mem_we    = 1'b1;
                count_d   = count_inc;
                if (count_inc == COUNT_FULL) begin
                    state_d    = S_DONE;
                    overflow_d = 1'b1;
                end else if (stop_edge) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                    tick_d  = '0;
                end
            end

            S_WAIT: begin
                recording = 1'b1;
                if (stop_edge) begin
                    state_d = S_DONE;
                end else if (tick_q == TICK_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sample RAM: not reset, so contents survive rst_a. rec_count never
    // exceeds MEMORY_SIZE-1 while writing, so the low bits never wrap.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[rec_count[ADDR_W-1:0]] <= wr_word;
        end
    end

    // Registered read; a read colliding with a write returns the old word.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_angle_sequence_recorder.sv
// -----------------------------------------------------------------------------
// tb_angle_sequence_recorder
//
// Directed bench for angle_sequence_recorder with TICKS=4, MEMORY_SIZE=4.
// A session-level reference model (active flag, cycles-until-next-sample,
// sample array) runs alongside the DUT and is compared every cycle; literal
// expectations at key points pin both the model and the DUT.
// -----------------------------------------------------------------------------
module tb_angle_sequence_recorder;

    localparam int ADDR_W = 2;
    localparam int MEM    = 4;
    localparam int TICKS  = 4;

    logic              clk = 1'b0;
    logic              rst_a = 1'b0;
    logic              rec_start = 1'b0;
    logic              rec_stop = 1'b0;
    logic [15:0]       servo1_angle = '0;
    logic              servo1_is_negative = 1'b0;
    logic [15:0]       servo2_angle = '0;
    logic              servo2_is_negative = 1'b0;
    logic [15:0]       servo3_angle = '0;
    logic              servo3_is_negative = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [50:0]       rd_data;
    logic [ADDR_W:0]   rec_count;
    logic              recording;
    logic              done;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    angle_sequence_recorder #(
        .TIME_MS       (1),
        .CLOCK_FREQ_HZ (4000),
        .MEMORY_SIZE   (4),
        .ADDR_W        (2)
    ) dut (
        .clk                (clk),
        .rst_a              (rst_a),
        .rec_start          (rec_start),
        .rec_stop           (rec_stop),
        .servo1_angle       (servo1_angle),
        .servo1_is_negative (servo1_is_negative),
        .servo2_angle       (servo2_angle),
        .servo2_is_negative (servo2_is_negative),
        .servo3_angle       (servo3_angle),
        .servo3_is_negative (servo3_is_negative),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .rec_count          (rec_count),
        .recording          (recording),
        .done               (done),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [50:0] mk(input logic n1, input logic [15:0] a1,
                                       input logic n2, input logic [15:0] a2,
                                       input logic n3, input logic [15:0] a3);
        return {n1, a1, n2, a2, n3, a3};
    endfunction

    // ---------------- reference model ----------------
    logic [50:0] m_mem [MEM];
    bit          m_known [MEM];
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_ovf = 0;
    int          m_count = 0;
    int          m_wait = 0;      // non-writing cycles left before next sample
    bit          m_prev_start = 0;
    bit          m_prev_stop = 0;
    logic [50:0] m_rd = '0;
    bit          m_rd_known = 1;

    always @(posedge clk or posedge rst_a) begin
        bit st;
        bit sp;
        if (rst_a) begin
            m_active = 0; m_done = 0; m_ovf = 0; m_count = 0; m_wait = 0;
            m_prev_start = 0; m_prev_stop = 0; m_rd = '0; m_rd_known = 1;
        end else begin
            st = rec_start && !m_prev_start;
            sp = rec_stop && !m_prev_stop;
            m_prev_start = rec_start;
            m_prev_stop  = rec_stop;
            m_rd       = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
            if (m_active) begin
                if (m_wait == 0) begin
                    m_mem[m_count]   = mk(servo1_is_negative, servo1_angle,
                                          servo2_is_negative, servo2_angle,
                                          servo3_is_negative, servo3_angle);
                    m_known[m_count] = 1;
                    m_count++;
                    if (m_count == MEM) begin
                        m_active = 0; m_done = 1; m_ovf = 1;
                    end else if (sp) begin
                        m_active = 0; m_done = 1;
                    end else begin
                        m_wait = TICKS - 1;
                    end
                end else if (sp) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_wait--;
                end
            end else if (st && !sp) begin
                m_active = 1; m_done = 0; m_ovf = 0; m_count = 0; m_wait = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst_a) begin
            chk("cyc_rec_count", 64'(rec_count), 64'(m_count));
            chk("cyc_recording", 64'(recording), 64'(m_active));
            chk("cyc_done",      64'(done),      64'(m_done));
            chk("cyc_overflow",  64'(overflow),  64'(m_ovf));
            if (m_rd_known) chk("cyc_rd_data", 64'(rd_data), 64'(m_rd));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst_a = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rec_count", 64'(rec_count), 64'd0);
        chk("reset_recording", 64'(recording), 64'd0);
        chk("reset_done",      64'(done),      64'd0);
        chk("reset_overflow",  64'(overflow),  64'd0);
        chk("reset_rd_data",   64'(rd_data),   64'd0);
        @(negedge clk);
        rst_a = 1'b0;

        // Simultaneous start and stop edges in IDLE: stop wins, nothing starts.
        rec_start = 1'b1;
        rec_stop  = 1'b1;
        @(negedge clk);
        chk("both_recording", 64'(recording), 64'd0);
        chk("both_rec_count", 64'(rec_count), 64'd0);
        chk("both_done",      64'(done),      64'd0);
        rec_start = 1'b0;
        rec_stop  = 1'b0;
        @(negedge clk);

        // First sample and ramp to memory full.
        servo1_angle = 16'h0010; servo1_is_negative = 1'b0;
        servo2_angle = 16'h0020; servo2_is_negative = 1'b1;
        servo3_angle = 16'h0030; servo3_is_negative = 1'b0;
        rd_addr   = 2'd0;
        rec_start = 1'b1;
        @(negedge clk);
        rec_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first_rec_count", 64'(rec_count), 64'd1);
                chk("first_recording", 64'(recording), 64'd1);
            end
            if (i == 1) begin
                chk("first_word0", 64'(rd_data),
                    64'(mk(1'b0, 16'h0010, 1'b1, 16'h0020, 1'b0, 16'h0030)));
            end
            servo1_angle = servo1_angle + 16'd1;
        end
        @(negedge clk);
        chk("full_done",      64'(done),      64'd1);
        chk("full_overflow",  64'(overflow),  64'd1);
        chk("full_rec_count", 64'(rec_count), 64'd4);
        chk("full_recording", 64'(recording), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            servo1_angle = servo1_angle + 16'd1;
        end

        // Read back stored samples.
        rd_addr = 2'd1;
        @(negedge clk);
        chk("read_word1", 64'(rd_data),
            64'(mk(1'b0, 16'h0014, 1'b1, 16'h0020, 1'b0, 16'h0030)));
        rd_addr = 2'd3;
        @(negedge clk);
        chk("read_word3", 64'(rd_data),
            64'(mk(1'b0, 16'h001C, 1'b1, 16'h0020, 1'b0, 16'h0030)));
        rd_addr = 2'd0;
        @(negedge clk);
        chk("read_word0_kept", 64'(rd_data),
            64'(mk(1'b0, 16'h0010, 1'b1, 16'h0020, 1'b0, 16'h0030)));

        // Start (held high) then stop edge 6 cycles later.
        rec_start = 1'b1;
        repeat (6) @(negedge clk);
        rec_stop = 1'b1;
        @(negedge clk);
        chk("stop_rec_count", 64'(rec_count), 64'd2);
        chk("stop_done",      64'(done),      64'd1);
        chk("stop_overflow",  64'(overflow),  64'd0);
        rec_stop = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_done",      64'(done),      64'd1);
        chk("held_recording", 64'(recording), 64'd0);
        chk("held_rec_count", 64'(rec_count), 64'd2);

        // Release and re-assert start, then reset mid-WAIT.
        rec_start = 1'b0;
        @(negedge clk);
        rec_start = 1'b1;
        servo1_angle = 16'h0100; servo1_is_negative = 1'b0;
        servo2_angle = 16'h0200; servo2_is_negative = 1'b0;
        servo3_angle = 16'h0300; servo3_is_negative = 1'b1;
        @(negedge clk);
        chk("restart_recording", 64'(recording), 64'd1);
        @(negedge clk);
        chk("restart_rec_count", 64'(rec_count), 64'd1);
        #2;
        rst_a     = 1'b1;
        rec_start = 1'b0;
        #1;
        chk("async_rec_count", 64'(rec_count), 64'd0);
        chk("async_recording", 64'(recording), 64'd0);
        chk("async_done",      64'(done),      64'd0);
        chk("async_overflow",  64'(overflow),  64'd0);
        chk("async_rd_data",   64'(rd_data),   64'd0);
        @(negedge clk);
        rst_a = 1'b0;

        // New recording writes addr 0; same-cycle read returns the old word.
        servo1_angle = 16'h0AAA; servo1_is_negative = 1'b1;
        servo2_angle = 16'h0BBB; servo2_is_negative = 1'b0;
        servo3_angle = 16'h0CCC; servo3_is_negative = 1'b1;
        rd_addr = 2'd0;
        @(negedge clk);
        rec_start = 1'b1;
        @(negedge clk);
        rec_start = 1'b0;
        @(negedge clk);
        chk("collide_rec_count", 64'(rec_count), 64'd1);
        chk("collide_old_word", 64'(rd_data),
            64'(mk(1'b0, 16'h0100, 1'b0, 16'h0200, 1'b1, 16'h0300)));
        @(negedge clk);
        chk("collide_new_word", 64'(rd_data),
            64'(mk(1'b1, 16'h0AAA, 1'b0, 16'h0BBB, 1'b1, 16'h0CCC)));
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
